// File: rtl/stage_n_if.sv
// Bus bundle for the stage_n trigger stage: command/strobe inputs, sample
// inputs and the three status/pulse outputs.
interface stage_n_if #(
    parameter int WIDTH = 32,
    parameter int LVL_W = 2
);
    logic [31:0]      cmd_i;
    logic             set_mask_i;
    logic             set_val_i;
    logic             set_cfg_i;
    logic             set_edge_i;
    logic             arm_i;
    logic             disarm_i;
    logic             stb_i;
    logic [WIDTH-1:0] smpls_i;
    logic [LVL_W-1:0] lvl_i;
    logic             armed_o;
    logic             match_o;
    logic             run_o;

    modport master (
        output cmd_i, set_mask_i, set_val_i, set_cfg_i, set_edge_i,
        output arm_i, disarm_i, stb_i, smpls_i, lvl_i,
        input  armed_o, match_o, run_o
    );

    modport slave (
        input  cmd_i, set_mask_i, set_val_i, set_cfg_i, set_edge_i,
        input  arm_i, disarm_i, stb_i, smpls_i, lvl_i,
        output armed_o, match_o, run_o
    );
endinterface

// File: rtl/stage_n.sv
// Trigger stage: masked value/level compare on strobed samples (parallel or
// serial), optional post-hit strobe delay. STAGE_EDGE_TRG_EN adds edge bits.
module stage_n #(
    parameter int WIDTH = 32,
    parameter int DLY_W = 16,
    parameter int LVL_W = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    stage_n_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMD  = 2'd1,
        MTCHD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [4:0]       chl_q, chl_d;
    logic             ser_q, ser_d;
    logic             act_q, act_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             match_q, match_d;
    logic             run_q, run_d;

    logic [15:0]      dly_raw_s;
    logic             ser_bit_s;
    logic [WIDTH-1:0] cmp_s;
    logic [WIDTH-1:0] miss_s;
    logic             hit_s;
    logic             fire_s;
    logic             arm_acc_s;
    logic [DLY_W:0]   cnt_inc_s;
    logic             unused_cmd;

    assign unused_cmd = ^bus.cmd_i;

    // Configuration register writes; strobes are one-hot so order is irrelevant
    always_comb begin
        mask_d    = mask_q;
        val_d     = val_q;
        dly_d     = dly_q;
        lvl_d     = lvl_q;
        chl_d     = chl_q;
        ser_d     = ser_q;
        act_d     = act_q;
        dly_raw_s = {bus.cmd_i[23:16], bus.cmd_i[31:24]};
        if (bus.set_mask_i) begin
            mask_d = bus.cmd_i[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (bus.set_val_i) begin
            val_d = bus.cmd_i[WIDTH-1:0];
        end else begin
            val_d = val_q;
        end
        if (bus.set_cfg_i) begin
            dly_d = DLY_W'(dly_raw_s);
            lvl_d = bus.cmd_i[8 +: LVL_W];
            chl_d = {bus.cmd_i[0], bus.cmd_i[15:12]};
            ser_d = bus.cmd_i[2];
            act_d = bus.cmd_i[3];
        end else begin
            dly_d = dly_q;
        end
    end

    // Serial channel select; channels at or above WIDTH read as 0
    always_comb begin
        ser_bit_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            ser_bit_s = (chl_q == 5'(i)) ? bus.smpls_i[i] : ser_bit_s;
        end
        if (bus.stb_i) begin
            shift_d = {shift_q[WIDTH-2:0], ser_bit_s};
        end else begin
            shift_d = shift_q;
        end
        // The serial compare sees the vector including this strobe's sample
        cmp_s = ser_q ? shift_d : bus.smpls_i;
    end

`ifdef STAGE_EDGE_TRG_EN
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [WIDTH-1:0] edge_ok_s;

    // Edge config, previous-sample capture and edge-aware mismatch vector
    always_comb begin
        edge_d     = edge_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (bus.set_edge_i) begin
            edge_d = bus.cmd_i[WIDTH-1:0];
        end else begin
            edge_d = edge_q;
        end
        if (bus.stb_i) begin
            prev_d = cmp_s;
        end else begin
            prev_d = prev_q;
        end
        if (arm_acc_s) begin
            prev_vld_d = 1'b0;
        end else if (bus.stb_i) begin
            prev_vld_d = 1'b1;
        end else begin
            prev_vld_d = prev_vld_q;
        end
        edge_ok_s = {WIDTH{prev_vld_q}} & (prev_q ^ val_q) & ~(cmp_s ^ val_q);
        miss_s    = ((cmp_s ^ val_q) & mask_q & ~edge_q) | (mask_q & edge_q & ~edge_ok_s);
    end

    // Edge-feature state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_q     <= {WIDTH{1'b0}};
            prev_q     <= {WIDTH{1'b0}};
            prev_vld_q <= 1'b0;
        end else begin
            edge_q     <= edge_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    logic unused_edge;
    assign unused_edge = bus.set_edge_i;

    // Plain masked equality
    always_comb begin
        miss_s = (cmp_s ^ val_q) & mask_q;
    end
`endif

    // Trigger condition
    always_comb begin
        hit_s = bus.stb_i && (miss_s == {WIDTH{1'b0}}) && (bus.lvl_i >= lvl_q);
    end

    // FSM next state, delay counter and pulse generation
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        fire_s    = 1'b0;
        arm_acc_s = 1'b0;
        cnt_inc_s = {1'b0, dly_cnt_q} + {{DLY_W{1'b0}}, 1'b1};
        case (state_q)
            IDLE: begin
                if (bus.arm_i && !bus.disarm_i) begin
                    state_d   = ARMD;
                    arm_acc_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMD: begin
                if (bus.disarm_i) begin
                    state_d = IDLE;
                end else if (hit_s) begin
                    if (dly_q == {DLY_W{1'b0}}) begin
                        state_d = IDLE;
                        fire_s  = 1'b1;
                    end else begin
                        state_d   = MTCHD;
                        dly_cnt_d = {DLY_W{1'b0}};
                    end
                end else begin
                    state_d = ARMD;
                end
            end
            MTCHD: begin
                if (bus.disarm_i) begin
                    state_d = IDLE;
                end else if (bus.stb_i) begin
                    if (cnt_inc_s == {1'b0, dly_q}) begin
                        state_d = IDLE;
                        fire_s  = 1'b1;
                    end else if (dly_cnt_q != {DLY_W{1'b1}}) begin
                        dly_cnt_d = cnt_inc_s[DLY_W-1:0];
                    end else begin
                        dly_cnt_d = dly_cnt_q;
                    end
                end else begin
                    state_d = MTCHD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        match_d = fire_s;
        run_d   = fire_s & act_q;
    end

    // State, configuration and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            dly_cnt_q <= {DLY_W{1'b0}};
            mask_q    <= {WIDTH{1'b0}};
            val_q     <= {WIDTH{1'b0}};
            dly_q     <= {DLY_W{1'b0}};
            lvl_q     <= {LVL_W{1'b0}};
            chl_q     <= 5'd0;
            ser_q     <= 1'b0;
            act_q     <= 1'b0;
            shift_q   <= {WIDTH{1'b0}};
            match_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            mask_q    <= mask_d;
            val_q     <= val_d;
            dly_q     <= dly_d;
            lvl_q     <= lvl_d;
            chl_q     <= chl_d;
            ser_q     <= ser_d;
            act_q     <= act_d;
            shift_q   <= shift_d;
            match_q   <= match_d;
            run_q     <= run_d;
        end
    end

    assign bus.armed_o = (state_q == ARMD);
    assign bus.match_o = match_q;
    assign bus.run_o   = run_q;

endmodule

// File: tb/tb_stage_n.sv
// Directed self-checking bench for stage_n; a second 16-channel instance
// shares the stimulus to exercise out-of-range serial channels.
module tb_stage_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    stage_n_if #(.WIDTH(32), .LVL_W(2)) bus ();
    stage_n_if #(.WIDTH(16), .LVL_W(2)) bus16 ();

    stage_n #(.WIDTH(32), .DLY_W(16), .LVL_W(2)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    stage_n #(.WIDTH(16), .DLY_W(16), .LVL_W(2)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(bus16));

    assign bus16.cmd_i      = bus.cmd_i;
    assign bus16.set_mask_i = bus.set_mask_i;
    assign bus16.set_val_i  = bus.set_val_i;
    assign bus16.set_cfg_i  = bus.set_cfg_i;
    assign bus16.set_edge_i = bus.set_edge_i;
    assign bus16.arm_i      = bus.arm_i;
    assign bus16.disarm_i   = bus.disarm_i;
    assign bus16.stb_i      = bus.stb_i;
    assign bus16.smpls_i    = bus.smpls_i[15:0];
    assign bus16.lvl_i      = bus.lvl_i;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cfgw(input logic [15:0] dly, input logic [1:0] lvl,
                                         input logic [4:0] chl, input logic ser, input logic act);
        logic [31:0] w;
        w = 32'd0;
        w[31:24] = dly[7:0];
        w[23:16] = dly[15:8];
        w[15:12] = chl[3:0];
        w[9:8]   = lvl;
        w[3]     = act;
        w[2]     = ser;
        w[0]     = chl[4];
        return w;
    endfunction

    // sel: 0 mask, 1 val, 2 cfg, 3 edge
    task automatic wr(input int sel, input logic [31:0] v);
        bus.cmd_i      = v;
        bus.set_mask_i = (sel == 0);
        bus.set_val_i  = (sel == 1);
        bus.set_cfg_i  = (sel == 2);
        bus.set_edge_i = (sel == 3);
        tick();
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
        bus.set_edge_i = 1'b0;
    endtask

    task automatic arm();
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
    endtask

    task automatic stb(input logic [31:0] s);
        bus.smpls_i = s;
        bus.stb_i   = 1'b1;
        tick();
        bus.stb_i   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.arm_i = 1'b1;
        rst = 1'b1;
        tick();
        n_run++; if (bus.armed_o !== 1'b0) begin n_fail++; $display("FAIL rst_armed: got %b want 0", bus.armed_o); end
        n_run++; if ({bus.match_o, bus.run_o} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %b want 00", {bus.match_o, bus.run_o}); end
        bus.arm_i = 1'b0;
        rst = 1'b0;
        tick();
        n_run++; if ({bus.armed_o, bus.match_o, bus.run_o} !== 3'b000) begin n_fail++; $display("FAIL rst_after: got %b want 000", {bus.armed_o, bus.match_o, bus.run_o}); end
    endtask

    task automatic test_basic();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        wr(2, cfgw(16'd0, 2'd0, 5'd0, 1'b0, 1'b1));
        arm();
        n_run++; if (bus.armed_o !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b want 1", bus.armed_o); end
        stb(32'h1234_5600);
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b10) begin n_fail++; $display("FAIL basic_nohit: got %b want 10", {bus.armed_o, bus.match_o}); end
        stb(32'h1234_565A);
        n_run++; if ({bus.armed_o, bus.match_o, bus.run_o} !== 3'b011) begin n_fail++; $display("FAIL basic_fire: got %b want 011", {bus.armed_o, bus.match_o, bus.run_o}); end
        tick();
        n_run++; if ({bus.match_o, bus.run_o} !== 2'b00) begin n_fail++; $display("FAIL basic_onecycle: got %b want 00", {bus.match_o, bus.run_o}); end
    endtask

    task automatic test_delay();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        wr(2, cfgw(16'd3, 2'd0, 5'd0, 1'b0, 1'b1));
        arm();
        stb(32'h0000_005A);
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b00) begin n_fail++; $display("FAIL dly_hit: got %b want 00", {bus.armed_o, bus.match_o}); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            stb(32'h0000_0000);
            if (k < 3) begin
                n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL dly_early%0d: got %b want 0", k, bus.match_o); end
            end else begin
                n_run++; if ({bus.match_o, bus.run_o} !== 2'b11) begin n_fail++; $display("FAIL dly_fire: got %b want 11", {bus.match_o, bus.run_o}); end
            end
        end
        tick();
        n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL dly_onecycle: got %b want 0", bus.match_o); end
        // Reconfigure delay while counting: 5 -> 2 after one post-hit strobe
        wr(2, cfgw(16'd5, 2'd0, 5'd0, 1'b0, 1'b0));
        arm();
        stb(32'h0000_005A);
        stb(32'h0000_0000);
        n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL dly_reconf_early: got %b want 0", bus.match_o); end
        wr(2, cfgw(16'd2, 2'd0, 5'd0, 1'b0, 1'b0));
        stb(32'h0000_0000);
        n_run++; if ({bus.match_o, bus.run_o} !== 2'b10) begin n_fail++; $display("FAIL dly_reconf_fire: got %b want 10", {bus.match_o, bus.run_o}); end
    endtask

    task automatic test_serial();
        logic [3:0] bits;
        bits = 4'b0101;
        do_reset();
        wr(0, 32'h0000_000F);
        wr(1, 32'h0000_000A);
        wr(2, cfgw(16'd0, 2'd0, 5'd4, 1'b1, 1'b0));
        arm();
        for (int k = 0; k < 4; k++) begin
            // Low nibble = 0xA would match a parallel compare; only ch4 matters
            stb({27'd0, bits[k], 4'hA});
            if (k < 3) begin
                n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL ser_early%0d: got %b want 0", k, bus.match_o); end
            end else begin
                n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL ser_fire: got %b want 1", bus.match_o); end
            end
        end
        // 16-channel instance, channel 31 out of range -> zeros shifted in
        do_reset();
        wr(0, 32'h0000_000F);
        wr(1, 32'h0000_000A);
        wr(2, cfgw(16'd0, 2'd0, 5'd31, 1'b1, 1'b0));
        arm();
        for (int k = 0; k < 4; k++) begin
            stb(32'hFFFF_FFFF);
            n_run++; if ({bus16.armed_o, bus16.match_o} !== 2'b10) begin n_fail++; $display("FAIL ser_oor%0d: got %b want 10", k, {bus16.armed_o, bus16.match_o}); end
        end
        wr(1, 32'h0000_0000);
        stb(32'hFFFF_FFFF);
        n_run++; if (bus16.match_o !== 1'b1) begin n_fail++; $display("FAIL ser_oor_val0: got %b want 1", bus16.match_o); end
        n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL ser_ch31_w32: got %b want 0", bus.match_o); end
    endtask

    task automatic test_level();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        wr(2, cfgw(16'd0, 2'd2, 5'd0, 1'b0, 1'b0));
        arm();
        bus.lvl_i = 2'd1;
        stb(32'h0000_005A);
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b10) begin n_fail++; $display("FAIL lvl_low: got %b want 10", {bus.armed_o, bus.match_o}); end
        bus.lvl_i = 2'd2;
        stb(32'h0000_005A);
        n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL lvl_eq: got %b want 1", bus.match_o); end
        bus.lvl_i = 2'd0;
    endtask

    task automatic test_disarm();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        wr(2, cfgw(16'd2, 2'd0, 5'd0, 1'b0, 1'b1));
        arm();
        stb(32'h0000_005A);
        bus.disarm_i = 1'b1;
        tick();
        bus.disarm_i = 1'b0;
        stb(32'h0000_005A);
        stb(32'h0000_005A);
        n_run++; if ({bus.armed_o, bus.match_o, bus.run_o} !== 3'b000) begin n_fail++; $display("FAIL dis_mtchd: got %b want 000", {bus.armed_o, bus.match_o, bus.run_o}); end
        // Disarm wins over a hit in ARMD
        wr(2, cfgw(16'd0, 2'd0, 5'd0, 1'b0, 1'b1));
        arm();
        bus.disarm_i = 1'b1;
        stb(32'h0000_005A);
        bus.disarm_i = 1'b0;
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b00) begin n_fail++; $display("FAIL dis_vs_hit: got %b want 00", {bus.armed_o, bus.match_o}); end
        // Reset while armed
        arm();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b00) begin n_fail++; $display("FAIL rst_armd: got %b want 00", {bus.armed_o, bus.match_o}); end
    endtask

    task automatic test_arm_stb_idle();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        bus.arm_i = 1'b1;
        stb(32'h0000_005A);
        bus.arm_i = 1'b0;
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b10) begin n_fail++; $display("FAIL armstb_noeval: got %b want 10", {bus.armed_o, bus.match_o}); end
        stb(32'h0000_005A);
        n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL armstb_next: got %b want 1", bus.match_o); end
        // Same-cycle arm still shifts the serial register
        do_reset();
        wr(0, 32'h0000_0003);
        wr(1, 32'h0000_0002);
        wr(2, cfgw(16'd0, 2'd0, 5'd0, 1'b1, 1'b0));
        bus.arm_i = 1'b1;
        stb(32'h0000_0001);
        bus.arm_i = 1'b0;
        stb(32'h0000_0000);
        n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL armstb_shift: got %b want 1", bus.match_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(0, 32'h0000_00FF);
        wr(1, 32'h0000_005A);
        wr(2, cfgw(16'd1, 2'd0, 5'd0, 1'b0, 1'b1));
        arm();
        stb(32'h0000_005A);
        stb(32'h0000_0000);
        n_run++; if ({bus.match_o, bus.run_o} !== 2'b11) begin n_fail++; $display("FAIL b2b_dly1: got %b want 11", {bus.match_o, bus.run_o}); end
        arm();
        n_run++; if ({bus.armed_o, bus.match_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_rearm: got %b want 10", {bus.armed_o, bus.match_o}); end
    endtask

    task automatic test_edge();
        do_reset();
        wr(0, 32'h0000_0001);
        wr(1, 32'h0000_0001);
        wr(3, 32'h0000_0001);
        arm();
        stb(32'h0000_0001);
`ifdef STAGE_EDGE_TRG_EN
        n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL edge_first: got %b want 0", bus.match_o); end
        stb(32'h0000_0000);
        n_run++; if (bus.match_o !== 1'b0) begin n_fail++; $display("FAIL edge_low: got %b want 0", bus.match_o); end
        stb(32'h0000_0001);
        n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL edge_rise: got %b want 1", bus.match_o); end
`else
        n_run++; if (bus.match_o !== 1'b1) begin n_fail++; $display("FAIL edge_ignored: got %b want 1", bus.match_o); end
`endif
    endtask

    initial begin
        bus.cmd_i      = 32'd0;
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
        bus.set_edge_i = 1'b0;
        bus.arm_i      = 1'b0;
        bus.disarm_i   = 1'b0;
        bus.stb_i      = 1'b0;
        bus.smpls_i    = 32'd0;
        bus.lvl_i      = 2'd0;
        tick();
        test_reset();
        test_basic();
        test_delay();
        test_serial();
        test_level();
        test_disarm();
        test_arm_stb_idle();
        test_back_to_back();
        test_edge();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_n.md
STAGE_N -- requirements
Module: stage_n

Interface
REQ-001 Parameter WIDTH, 32, number of sampled channels; legal 8..32, multiple of 8.
REQ-002 Parameter DLY_W, 16, width of delay register and delay counter.
REQ-003 Parameter LVL_W, 2, width of level fields.
REQ-004 clk_i  in  1  system clock, single clock domain.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 cmd_i  in  32  command word; byte 0 = bits 7:0 (LSByte).
REQ-007 set_mask_i / set_val_i / set_cfg_i / set_edge_i  in  1 each  one-cycle write strobes.
REQ-008 arm_i  in  1  arm request pulse.
REQ-009 disarm_i  in  1  abort pulse; returns block to IDLE.
REQ-010 stb_i  in  1  new-sample strobe.
REQ-011 smpls_i  in  WIDTH  sampled channels.
REQ-012 lvl_i  in  LVL_W  currently active trigger level.
REQ-013 armed_o  out  1  high while state is ARMD.
REQ-014 match_o  out  1  registered one-cycle trigger-fired pulse.
REQ-015 run_o  out  1  registered one-cycle pulse; equals r_act when match_o fires, else 0.

Function
REQ-016 Writes: set_mask_i loads r_mask <= cmd_i[WIDTH-1:0]; set_val_i loads r_val <= cmd_i[WIDTH-1:0]; writes take effect the next cycle, in any state.
REQ-017 set_cfg_i loads r_dly <= {byte2, byte3} truncated/zero-extended to DLY_W; r_lvl <= byte1[LVL_W-1:0]; r_chl <= {byte0[0], byte1[7:4]}; r_ser <= byte0[2]; r_act <= byte0[3].
REQ-018 Compare vector: r_ser=1 uses the serial shift register, r_ser=0 uses smpls_i.
REQ-019 Serial shift register is WIDTH bits, shifts left on every stb_i, and inserts smpls_i[r_chl] at bit 0; if r_chl >= WIDTH it inserts 0.
REQ-020 Condition: hit = (((cmp ^ r_val) & r_mask) == 0) AND (lvl_i >= r_lvl) AND stb_i; the condition is evaluated only in cycles with stb_i=1.
REQ-021 FSM IDLE: arm_i -> ARMD.
REQ-022 FSM ARMD: disarm_i -> IDLE; hit with r_dly=0 -> IDLE and pulse outputs; hit with r_dly>0 -> MTCHD with dly_cnt=0.
REQ-023 FSM MTCHD: disarm_i -> IDLE with no pulse; each stb_i increments dly_cnt; the stb_i that makes dly_cnt+1 == r_dly -> IDLE and pulse outputs.
REQ-024 Latency: match_o (and run_o if r_act) is high exactly in the cycle after the firing stb_i, for one cycle; with r_dly=N it fires after the hit stb plus N further stbs.
REQ-025 dly_cnt never wraps; r_dly is sampled at its current value each cycle (a reconfiguration in MTCHD applies immediately).
REQ-026 arm_i in ARMD or MTCHD is ignored; disarm_i has priority over arm_i and over a hit in the same cycle.
REQ-027 arm_i and stb_i in the same IDLE cycle: arm is accepted; that sample is not evaluated, but it still shifts the serial register.
REQ-028 All write strobes are one-hot0 by contract; behaviour under violation is undefined.

Reset
REQ-029 rst_i=1 at a clock edge: state=IDLE, dly_cnt=0, shift register=0, previous-sample register=0, and all config registers=0; this holds mid-operation.
REQ-030 armed_o, match_o and run_o SHALL be 0 during and in the first cycle after reset.

Configuration
REQ-031 Macro STAGE_EDGE_TRG_EN compiles in the edge-trigger feature.
REQ-032 With the macro: set_edge_i loads r_edge <= cmd_i[WIDTH-1:0]; a previous-sample register captures the compare vector on each stb_i.
REQ-033 With the macro, a bit with r_edge=1 and r_mask=1 matches only if prev != r_val and cmp == r_val on that bit.
REQ-034 With the macro, edge bits never match on the first stb_i after entering ARMD, because the previous-sample register is invalidated on arm.
REQ-035 Without the macro: set_edge_i is present but ignored; no r_edge or previous-sample register exists; behaviour follows REQ-020 only.

Verification
REQ-036 mask=0x000000FF, val=0x5A, dly=0, arm, stb with smpls=0x1234565A -> match_o=1 exactly one cycle later, then IDLE.
REQ-037 cfg act=1, dly=3, hit on stb, then 3 further stbs spaced 2 cycles apart -> match_o=run_o=1 one cycle after the 3rd stb; no pulse earlier.
REQ-038 r_ser=1, r_chl=4, mask=0xF, val=0xA, drive ch4 = 1,0,1,0 on 4 stbs -> match after the 4th stb; with r_chl=31 at WIDTH=16, never match unless val&mask=0.
REQ-039 lvl=2, lvl_i=1 with matching samples -> no match; lvl_i=2 -> match; disarm_i in MTCHD -> IDLE, no pulse; rst_i in ARMD -> IDLE, armed_o=0.
REQ-040 STAGE_EDGE_TRG_EN, edge=mask=0x1, val=0x1: first stb after arm smpls=1 -> no match; then 0 followed by 1 -> match after the second of those stbs; without the macro the first stb matches.
